// File: rtl/mac_seq.sv
// mac_seq: address/enable sequencer for one LSTM multiply-accumulate lane.
// Streams N operand addresses and drives the MAC clear/accumulate controls.
module mac_seq #(
    parameter int ADDR_WIDTH = 8,
    parameter int LEN_WIDTH  = 8
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  i_start,
    input  logic                  i_abort,
    input  logic [LEN_WIDTH-1:0]  i_len,
    input  logic [ADDR_WIDTH-1:0] i_base,
    output logic                  o_rd_en,
    output logic [ADDR_WIDTH-1:0] o_addr,
    output logic                  o_mac_clr,
    output logic                  o_acc,
    output logic                  o_busy,
    output logic                  o_done
);

    typedef enum logic [2:0] {
        IDLE,
        CLEAR,
        RUN,
        DRAIN,
        DONE
    } state_t;

    state_t                state;
    state_t                state_n;
    logic [LEN_WIDTH-1:0]  len;
    logic [LEN_WIDTH-1:0]  len_n;
    logic [LEN_WIDTH-1:0]  cnt;
    logic [LEN_WIDTH-1:0]  cnt_n;
    logic [ADDR_WIDTH-1:0] addr_n;
    logic                  rd_n;
    logic                  clr_n;
    logic                  acc_n;
    logic                  busy_n;
    logic                  done_n;

    // Outputs are computed for the upcoming state and registered with it.
    always_comb begin
        state_n = state;
        len_n   = len;
        cnt_n   = cnt;
        addr_n  = o_addr;
        rd_n    = 1'b0;
        clr_n   = 1'b0;
        busy_n  = 1'b0;
        done_n  = 1'b0;
        acc_n   = 1'b0;

        unique case (state)
            IDLE, DONE: begin
                state_n = IDLE;
                if (i_start) begin
                    state_n = CLEAR;
                    len_n   = i_len;
                    cnt_n   = '0;
                    clr_n   = 1'b1;
                    busy_n  = 1'b1;
                    if (i_len != '0) begin
                        rd_n   = 1'b1;
                        addr_n = i_base;
                    end
                end
            end
            CLEAR: begin
                if (len == '0) begin
                    state_n = DONE;
                    done_n  = 1'b1;
                end else if (len == LEN_WIDTH'(1)) begin
                    state_n = DRAIN;
                    busy_n  = 1'b1;
                end else begin
                    state_n = RUN;
                    busy_n  = 1'b1;
                    rd_n    = 1'b1;
                    addr_n  = o_addr + 1'b1;
                    cnt_n   = cnt + 1'b1;
                end
            end
            RUN: begin
                busy_n = 1'b1;
                // cnt tracks the term index of the address currently issued.
                if (cnt == len - 1'b1) begin
                    state_n = DRAIN;
                end else begin
                    rd_n   = 1'b1;
                    addr_n = o_addr + 1'b1;
                    cnt_n  = cnt + 1'b1;
                end
            end
            DRAIN: begin
                state_n = DONE;
                done_n  = 1'b1;
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        if (i_abort && (state inside {CLEAR, RUN, DRAIN})) begin
            state_n = IDLE;
            cnt_n   = '0;
            addr_n  = '0;
            rd_n    = 1'b0;
            clr_n   = 1'b0;
            busy_n  = 1'b0;
            done_n  = 1'b0;
        end

        // Read data arrives one cycle after the address.
        acc_n = o_rd_en && (state_n != IDLE);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            len       <= '0;
            cnt       <= '0;
            o_addr    <= '0;
            o_rd_en   <= 1'b0;
            o_mac_clr <= 1'b0;
            o_acc     <= 1'b0;
            o_busy    <= 1'b0;
            o_done    <= 1'b0;
        end else begin
            state     <= state_n;
            len       <= len_n;
            cnt       <= cnt_n;
            o_addr    <= addr_n;
            o_rd_en   <= rd_n;
            o_mac_clr <= clr_n;
            o_acc     <= acc_n;
            o_busy    <= busy_n;
            o_done    <= done_n;
        end
    end

endmodule

// File: tb/tb_mac_seq.sv
// tb_mac_seq: randomized self-checking bench for mac_seq, with an operand
// memory and Q8.24 MAC attached so the finished dot product is checked too.
module tb_mac_seq;

    localparam int AW = 8;
    localparam int LW = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic          i_start = 1'b0;
    logic          i_abort = 1'b0;
    logic [LW-1:0] i_len = '0;
    logic [AW-1:0] i_base = '0;
    logic          o_rd_en;
    logic [AW-1:0] o_addr;
    logic          o_mac_clr;
    logic          o_acc;
    logic          o_busy;
    logic          o_done;

    mac_seq #(.ADDR_WIDTH(AW), .LEN_WIDTH(LW)) dut (
        .clk       (clk),
        .rst       (rst),
        .i_start   (i_start),
        .i_abort   (i_abort),
        .i_len     (i_len),
        .i_base    (i_base),
        .o_rd_en   (o_rd_en),
        .o_addr    (o_addr),
        .o_mac_clr (o_mac_clr),
        .o_acc     (o_acc),
        .o_busy    (o_busy),
        .o_done    (o_done)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    logic [31:0]   xmem [256];
    logic [31:0]   wmem [256];
    logic [31:0]   rdx = '0;
    logic [31:0]   rdw = '0;
    logic [31:0]   mac = '0;
    logic [AW-1:0] exp_addr = '0;

    function automatic logic [31:0] fmul(input logic [31:0] a, input logic [31:0] b);
        longint p;
        p = longint'($signed(a)) * longint'($signed(b));
        return p[55:24];
    endfunction

    // Memory with one-cycle read latency feeding a MAC.
    always @(posedge clk) begin
        if (o_rd_en) begin
            rdx <= xmem[o_addr];
            rdw <= wmem[o_addr];
        end
        if (o_mac_clr)
            mac <= '0;
        else if (o_acc)
            mac <= mac + fmul(rdx, rdw);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] want);
        n_chk++;
        if (got === want)
            n_pass++;
        else
            $display("FAIL %s: got %0h expected %0h", tag, got, want);
    endtask

    function automatic logic [12:0] obs();
        return {o_mac_clr, o_rd_en, o_acc, o_busy, o_done, o_addr};
    endfunction

    // Called #1 after an edge while the DUT is in IDLE or DONE.
    task automatic run_seq(input int n, input int base, input bit hold,
                           input bit abort_start, input int abort_c);
        int          last;
        int          accs;
        bit          erd;
        logic [31:0] esum;
        logic [7:0]  a;
        logic [12:0] e;
        last = (n == 0) ? 2 : n + 2;
        esum = '0;
        for (int i = 0; i < n; i++) begin
            a = 8'(base + i);
            esum = esum + fmul(xmem[a], wmem[a]);
        end
        i_start = 1'b1;
        i_len   = LW'(n);
        i_base  = AW'(base);
        i_abort = abort_start;
        @(posedge clk); #1;
        i_abort = 1'b0;
        accs = 0;
        for (int c = 1; c <= last; c++) begin
            erd = (n >= 1) && (c <= n);
            if (erd) exp_addr = AW'(base + c - 1);
            e = {c == 1, erd, (n >= 1) && (c >= 2) && (c <= n + 1),
                 c < last, c == last, exp_addr};
            check($sformatf("seq n=%0d base=%0h c=%0d", n, base, c), 64'(obs()), 64'(e));
            accs += int'(o_acc);
            if (c == last) begin
                check($sformatf("acc_count n=%0d", n), 64'(accs), 64'(n));
                check($sformatf("mac n=%0d", n), 64'(mac), 64'(esum));
                i_start = 1'b0;
            end else begin
                i_start = hold ? 1'b1 : 1'($urandom);
                i_len   = LW'($urandom);
                i_base  = AW'($urandom);
                if (c == abort_c) begin
                    i_abort = 1'b1;
                    @(posedge clk); #1;
                    i_abort  = 1'b0;
                    i_start  = 1'b0;
                    exp_addr = '0;
                    check($sformatf("abort n=%0d c=%0d", n, c), 64'(obs()), 64'd0);
                    return;
                end
                @(posedge clk); #1;
            end
        end
    endtask

    task automatic idle(input int k);
        repeat (k) begin
            i_abort = 1'($urandom);
            @(posedge clk); #1;
            check("idle", 64'(obs()), 64'({5'b0, exp_addr}));
        end
        i_abort = 1'b0;
    endtask

    int rn;
    int rac;

    initial begin
        for (int i = 0; i < 256; i++) begin
            xmem[i] = $urandom_range(0, 67108863) - 32'd33554432;
            wmem[i] = $urandom_range(0, 67108863) - 32'd33554432;
        end
        for (int i = 0; i < 4; i++) begin
            xmem[16 + i] = 32'(i + 1) << 24;
            wmem[16 + i] = 32'h0080_0000;
        end

        repeat (3) @(posedge clk);
        #1;
        check("reset", 64'(obs()), 64'd0);
        rst = 1'b1;

        run_seq(4, 'h10, 1'b0, 1'b0, 0);
        check("mac_dot_5.0", 64'(mac), 64'h0500_0000);
        idle(2);
        run_seq(1, 'h33, 1'b0, 1'b0, 0);
        idle(1);
        run_seq(0, 'h50, 1'b0, 1'b0, 0);
        check("mac_n0", 64'(mac), 64'd0);
        idle(1);
        run_seq(4, 'hFE, 1'b0, 1'b0, 0);
        idle(1);
        repeat (3) run_seq(3, int'($urandom_range(0, 255)), 1'b1, 1'b0, 0);
        idle(2);
        run_seq(5, 'h20, 1'b0, 1'b0, 3);
        idle(3);
        run_seq(3, 'h60, 1'b0, 1'b1, 0);
        idle(1);

        i_start = 1'b1;
        i_len   = LW'(6);
        i_base  = AW'('h40);
        @(posedge clk); #1;
        i_start = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        #2 rst = 1'b0;
        #1;
        check("async_reset", 64'(obs()), 64'd0);
        exp_addr = '0;
        @(posedge clk); #1;
        check("reset_hold", 64'(obs()), 64'd0);
        rst = 1'b1;
        run_seq(2, 'h80, 1'b0, 1'b0, 0);
        idle(1);

        run_seq(255, int'($urandom_range(0, 255)), 1'b0, 1'b0, 0);

        repeat (24) begin
            rn  = int'($urandom_range(0, 16));
            rac = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, (rn == 0) ? 1 : rn + 1)) : 0;
            run_seq(rn, int'($urandom_range(0, 255)), 1'($urandom), 1'($urandom), rac);
            idle(int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule

// File: doc/mac_seq.md
# mac_seq

Sequencer for one multiply-and-accumulate lane in the LSTM datapath. On a start pulse it clears the MAC and streams N operand addresses from a base address to the x/weight memories. Memory read latency is one cycle, so it asserts the MAC accumulate enable one cycle behind each address. When the last product has been registered it pulses done, and the MAC output then holds the finished dot product.

## Interface
- ADDR_WIDTH, 8, operand memory address width
- LEN_WIDTH, 8, width of term-count input; max N = 2^LEN_WIDTH − 1
- clk  in  1  clock, rising edge
- rst  in  1  asynchronous, active-low reset (one clock; reset is asynchronous and active-low)
- i_start  in  1  start request, sampled in IDLE or DONE
- i_abort  in  1  abort current sequence
- i_len  in  LEN_WIDTH  number of terms N, unsigned, latched on accepted start
- i_base  in  ADDR_WIDTH  first operand address, latched on accepted start
- o_rd_en  out  1  operand memory read enable
- o_addr  out  ADDR_WIDTH  operand memory read address
- o_mac_clr  out  1  clear pulse to MAC reset input, active-high
- o_acc  out  1  MAC accumulate enable
- o_busy  out  1  high in CLEAR, RUN, DRAIN
- o_done  out  1  one-cycle pulse; MAC output valid this cycle

## Operation
- Outputs are registered and decoded from the state and counters.
- States: IDLE, CLEAR, RUN, DRAIN, DONE.
- IDLE: all outputs 0. i_start=1 → latch i_len/i_base, go to CLEAR.
- CLEAR (1 cycle): o_mac_clr=1.
  - If N≥1: o_rd_en=1, o_addr=base.
  - Next state: N=0 → DONE; N=1 → DRAIN; else → RUN.
- RUN (N−1 cycles): o_rd_en=1, o_addr = base+1 … base+N−1, incremented modulo 2^ADDR_WIDTH. Wrap past all-ones is legal: base=0xFE, N=4 → FE, FF, 00, 01. After the address base+N−1 is issued → DRAIN.
- o_acc is o_rd_en delayed by exactly one cycle. Consequences:
  - o_acc=0 in CLEAR.
  - o_acc=1 in every RUN cycle and in DRAIN.
  - o_acc=1 for exactly N cycles per sequence.
- DRAIN (1 cycle): o_rd_en=0, o_acc=1 for the last term → DONE.
- DONE (1 cycle): o_done=1, o_acc=0. MAC output equals Σ x·w.
  - i_start=1 in the same cycle → CLEAR directly (back-to-back sequence, no idle gap).
  - Otherwise → IDLE.
- i_start outside IDLE/DONE is ignored; i_len/i_base are not re-latched.
- i_abort=1 in CLEAR, RUN or DRAIN → IDLE next cycle.
  - All outputs drop to 0 next cycle; o_done is not pulsed.
  - The MAC contents are undefined after an abort.
  - i_abort has priority over i_start.
  - i_abort in IDLE/DONE has no effect.
- o_addr holds its last value when o_rd_en=0; o_addr is 0 after reset.
- Internal term counter is LEN_WIDTH bits and never overflows: maximum count is N−1.

## Timing
- Start accepted at edge E0.
- CLEAR is in cycle 1, RUN in cycles 2..N, DRAIN in cycle N+1, DONE in cycle N+2.
- Start-to-done latency is N+2 cycles for N≥1, and 2 cycles for N=0.
- Back-to-back sequences issue one start every N+2 cycles.
- o_busy=1 for exactly N+1 cycles (N≥1).
- On rst low, immediately and asynchronously:
  - state = IDLE;
  - all outputs and counters = 0, including o_addr.
- Reset mid-sequence discards the sequence with no o_done.
- First start is accepted at the first rising edge after rst deasserts.

## Test plan
- **N=4, base=0x10:** start pulse →
  - o_mac_clr in cycle 1;
  - o_addr 10,11,12,13 in cycles 1–4;
  - o_acc in cycles 2–5;
  - o_done in cycle 6.
  - With x = 1.0, 2.0, 3.0, 4.0 and w = 0.5 (FRAC=24), the MAC output is 0x05000000 in cycle 6.
- **N=1 and N=0:**
  - N=1 gives CLEAR→DRAIN→DONE, one o_acc, o_done in cycle 3.
  - N=0 gives o_mac_clr, no o_rd_en, no o_acc, o_done in cycle 2, MAC output 0.
- **Wrap:** base=0xFE, N=4 → o_addr FE,FF,00,01; o_acc count is 4.
- **Back-to-back:** i_start held high continuously with N=3 → DONE is followed immediately by CLEAR, o_done every 5 cycles. Start pulses during RUN are ignored, and the latched len is unchanged.
- **Abort:** i_abort in the 2nd RUN cycle → next cycle IDLE, all outputs 0, no o_done. i_abort together with i_start in IDLE → no effect, start accepted.
- **Reset:** rst low mid-RUN (between edges) → outputs 0 asynchronously, state IDLE. After release, a new start with N=2 completes in 4 cycles.
